// File: rtl/addr_signed_serial_ft.sv
// rtl/addr_signed_serial_ft.sv - digit-serial signed adder with duplicated, cross-checked digit lane
module addr_signed_serial_ft #(
   parameter int W     = 8,
   parameter int D     = 2,
   parameter int CHECK = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_sum,
   output logic         out_err,
   output logic         busy
);

   localparam int N  = W / D;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t        state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          c_q;
   logic [IW-1:0] idx;
   logic [W:0]    sum_q;
   logic          err_q;

   logic [D-1:0]  a_dig;
   logic [D-1:0]  b_dig;
   logic [D-1:0]  m_dig;
   logic          m_co;
   logic          mismatch;

   // Main lane: add the current digit pair plus the running carry
   always_comb begin
      a_dig         = a_q[idx*D +: D];
      b_dig         = b_q[idx*D +: D];
      {m_co, m_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, c_q};
   end

   generate
      if (CHECK != 0) begin : g_shadow
         logic [W-1:0] sa_q;
         logic [W-1:0] sb_q;
         logic         sc_q;
         logic [D-1:0] s_dig;
         logic         s_co;

         // Shadow lane: same digit add from its own operand copy and carry
         always_comb begin
            {s_co, s_dig} = {1'b0, sa_q[idx*D +: D]} + {1'b0, sb_q[idx*D +: D]}
                          + {{D{1'b0}}, sc_q};
         end

         // Shadow operand and carry registers, loaded and advanced alongside the main lane
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sa_q <= '0;
               sb_q <= '0;
               sc_q <= 1'b0;
            end else begin
               if (state == S_IDLE && in_valid && in_ready) begin
                  sa_q <= in_a;
                  sb_q <= in_b;
                  sc_q <= 1'b0;
               end else if (state == S_ADD) begin
                  sc_q <= s_co;
               end
            end
         end

         assign mismatch = (s_dig != m_dig) || (s_co != m_co);
      end else begin : g_noshadow
         assign mismatch = 1'b0;
      end
   endgenerate

   // Transaction FSM with registered handshake outputs and result assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= 1'b0;
         idx       <= '0;
         sum_q     <= '0;
         err_q     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  a_q      <= in_a;
                  b_q      <= in_b;
                  c_q      <= 1'b0;
                  idx      <= '0;
                  err_q    <= 1'b0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_ADD;
               end
            end
            S_ADD: begin
               sum_q[idx*D +: D] <= m_dig;
               c_q               <= m_co;
               err_q             <= err_q | mismatch;
               if (idx == LAST) begin
                  // carry out of the top bit completes the sign extension
                  sum_q[W]  <= a_q[W-1] ^ b_q[W-1] ^ m_co;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   assign out_sum = sum_q;
   assign out_err = (CHECK != 0) ? err_q : 1'b0;

endmodule

// File: tb/tb_addr_signed_serial_ft.sv
// tb/tb_addr_signed_serial_ft.sv - scoreboard bench for addr_signed_serial_ft
module tb_addr_signed_serial_ft;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, out_err, busy;
   logic [7:0] in_a, in_b;
   logic [8:0] out_sum;

   logic       x_valid;
   logic [7:0] x_a, x_b;
   logic       r8, ov8, oe8, b8;
   logic       r1, ov1, oe1, b1;
   logic [8:0] os8, os1;

   addr_signed_serial_ft #(.W(8), .D(2), .CHECK(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_err(out_err), .busy(busy));

   addr_signed_serial_ft #(.W(8), .D(8), .CHECK(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r8),
      .in_a(x_a), .in_b(x_b), .out_valid(ov8), .out_ready(1'b1),
      .out_sum(os8), .out_err(oe8), .busy(b8));

   addr_signed_serial_ft #(.W(8), .D(1), .CHECK(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r1),
      .in_a(x_a), .in_b(x_b), .out_valid(ov1), .out_ready(1'b1),
      .out_sum(os1), .out_err(oe1), .busy(b1));

   typedef struct {
      logic [8:0] sum;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   logic [8:0] q8[$];
   logic [8:0] q1[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
      return {a[7], a} + {b[7], b};
   endfunction

   task automatic start_txn(input logic [7:0] a, input logic [7:0] b, input logic e);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'(1));
      in_a = a; in_b = b; in_valid = 1'b1;
      sb.push_back('{ref_sum(a, b), e});
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
      chk("busy_in_add", 32'(busy), 32'(1));
      chk("in_ready_in_add", 32'(in_ready), 32'(0));
   endtask

   task automatic finish_txn(input int hold);
      exp_t       e;
      logic [8:0] s;
      int         n = 0;
      out_ready = (hold == 0);
      while (!out_valid && n < 30) begin
         @(posedge clk); #1; n++;
      end
      chk("out_valid_wait", 32'(out_valid), 32'(1));
      chk("latency", 32'(cyc - acc_cyc), 32'(4));
      e = sb.pop_front();
      chk("out_sum", 32'(out_sum), 32'(e.sum));
      chk("out_err", 32'(out_err), 32'(e.err));
      s = out_sum;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(out_valid), 32'(1));
         chk("hold_sum", 32'(out_sum), 32'(s));
         chk("hold_in_ready", 32'(in_ready), 32'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("valid_drop", 32'(out_valid), 32'(0));
      chk("in_ready_back", 32'(in_ready), 32'(1));
      chk("busy_idle", 32'(busy), 32'(0));
      chk("sum_kept", 32'(out_sum), 32'(e.sum));
   endtask

   task automatic alt_vec(input logic [7:0] a, input logic [7:0] b);
      int         l8 = -1;
      int         l1 = -1;
      logic [8:0] e;
      chk("alt_ready", 32'({r8, r1}), 32'(3));
      x_a = a; x_b = b; x_valid = 1'b1;
      q8.push_back(ref_sum(a, b));
      q1.push_back(ref_sum(a, b));
      @(posedge clk); #1;
      x_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (ov8 && l8 < 0) begin
            l8 = k;
            e = q8.pop_front();
            chk("d8_sum", 32'(os8), 32'(e));
            chk("d8_err", 32'(oe8), 32'(0));
         end
         if (ov1 && l1 < 0) begin
            l1 = k;
            e = q1.pop_front();
            chk("d1_sum", 32'(os1), 32'(e));
            chk("d1_err", 32'(oe1), 32'(0));
         end
      end
      chk("d8_latency", 32'(l8), 32'(1));
      chk("d1_latency", 32'(l1), 32'(8));
   endtask

   initial begin
      logic [7:0] ca[7];
      logic [7:0] cb[7];
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
      x_valid = 1'b0; x_a = '0; x_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_sum", 32'(out_sum), 32'(0));
      chk("rst_out_err", 32'(out_err), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      start_txn(8'd127, 8'd1, 1'b0);
      finish_txn(0);
      chk("t1_value", 32'(out_sum), 32'h080);
      start_txn(8'h80, 8'h80, 1'b0);
      finish_txn(0);
      chk("t2a_value", 32'(out_sum), 32'h100);
      start_txn(8'hFF, 8'h01, 1'b0);
      finish_txn(0);
      chk("t2b_value", 32'(out_sum), 32'h000);

      start_txn(8'h35, 8'hC9, 1'b0);
      finish_txn(5);

      // reset during the second ADD cycle
      in_a = 8'd100; in_b = 8'd27; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'(0));
      chk("mid_rst_sum", 32'(out_sum), 32'(0));
      chk("mid_rst_err", 32'(out_err), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("no_partial_valid", 32'(out_valid), 32'(0));
      end
      start_txn(8'd5, 8'hF9, 1'b0);
      finish_txn(0);
      chk("t4_value", 32'(out_sum), 32'h1FE);

      // shadow carry upset during ADD
      start_txn(8'h00, 8'h00, 1'b1);
      force dut.g_shadow.sc_q = 1'b1;
      @(posedge clk); #1;
      release dut.g_shadow.sc_q;
      finish_txn(0);
      start_txn(8'h12, 8'h34, 1'b0);
      finish_txn(0);

      for (int i = 0; i < 20; i++) begin
         start_txn(8'($urandom), 8'($urandom), 1'b0);
         finish_txn(i % 3);
      end

      ca = '{8'd127, 8'h80, 8'hFF, 8'h80, 8'd127, 8'h00, 8'hFF};
      cb = '{8'd1,   8'h80, 8'h01, 8'd127, 8'd127, 8'h00, 8'hFF};
      for (int i = 0; i < 7; i++) alt_vec(ca[i], cb[i]);
      for (int i = 0; i < 300; i++) alt_vec(8'($urandom), 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
